// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the PCIe TRN receive path: fmt/type codes,
// header field bit positions within beat 0, FSM state encodings and a
// DW byte-swap helper. PCIE_RX_MEM64_EN enables the ST_DATA state for
// 4DW memory requests.
package pcie_tlp_pkg;

  // {fmt[1:0], type[4:0]} codes of the memory requests we decode
  localparam logic [6:0] MRD32 = 7'b00_00000;
  localparam logic [6:0] MWR32 = 7'b10_00000;
  localparam logic [6:0] MRD64 = 7'b01_00000;
  localparam logic [6:0] MWR64 = 7'b11_00000;

  // Field positions in beat 0 = {DW0, DW1}, DW0 in [63:32]
  localparam int FMT_HI  = 62;
  localparam int FMT_LO  = 61;
  localparam int TYPE_HI = 60;
  localparam int TYPE_LO = 56;
  localparam int TC_HI   = 54;
  localparam int TC_LO   = 52;
  localparam int EP_BIT  = 46;
  localparam int ATTR_HI = 45;
  localparam int ATTR_LO = 44;
  localparam int LEN_HI  = 41;
  localparam int LEN_LO  = 32;
  localparam int RID_HI  = 31;
  localparam int RID_LO  = 16;
  localparam int TAG_HI  = 15;
  localparam int TAG_LO  = 8;
  localparam int FBE_HI  = 3;
  localparam int FBE_LO  = 0;

  // Receive FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_RD_HOLD = 3'd2;
  localparam logic [2:0] ST_DISCARD = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;

  // TLP payload DWs arrive big-endian; the write port is little-endian
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/pcie_tlp_hdr_dec.sv
// Combinational beat-0 decode: extracts the header fields and flags
// whether the TLP is a supported single-DW memory request to our BAR.
// PCIE_RX_MEM64_EN additionally admits MemRd64/MemWr64.
module pcie_tlp_hdr_dec
  import pcie_tlp_pkg::*;
#(
  parameter int BAR_SEL = 0
) (
  input  logic [63:0] i_beat,
  input  logic [6:0]  i_bar_hit_n,
  output logic        o_ok,
  output logic        o_is_wr,
  output logic        o_is_64,
  output logic        o_ep,
  output logic [2:0]  o_tc,
  output logic [1:0]  o_attr,
  output logic [15:0] o_rid,
  output logic [7:0]  o_tag,
  output logic [3:0]  o_be
);

  logic [6:0] w_fmt_type;
  logic       w_len_one;
  logic       w_bar_hit;
  logic       w_kind_ok;
  logic       w_unused;

  assign w_fmt_type = {i_beat[FMT_HI:FMT_LO], i_beat[TYPE_HI:TYPE_LO]};
  assign w_len_one  = (i_beat[LEN_HI:LEN_LO] == 10'd1);
  assign w_bar_hit  = ~i_bar_hit_n[BAR_SEL];

  // Classify fmt/type against the memory request codes this block serves
  always_comb begin
    w_kind_ok = (w_fmt_type == MRD32) || (w_fmt_type == MWR32);
`ifdef PCIE_RX_MEM64_EN
    w_kind_ok = w_kind_ok || (w_fmt_type == MRD64) || (w_fmt_type == MWR64);
`endif
  end

  assign o_ok    = w_kind_ok & w_len_one & w_bar_hit;
  assign o_is_wr = i_beat[FMT_HI];
  assign o_is_64 = i_beat[FMT_LO];
  assign o_ep    = i_beat[EP_BIT];
  assign o_tc    = i_beat[TC_HI:TC_LO];
  assign o_attr  = i_beat[ATTR_HI:ATTR_LO];
  assign o_rid   = i_beat[RID_HI:RID_LO];
  assign o_tag   = i_beat[TAG_HI:TAG_LO];
  assign o_be    = i_beat[FBE_HI:FBE_LO];

  // Reserved header bits and the other BAR hits carry no meaning here
  assign w_unused = ^{i_beat[63], i_beat[55], i_beat[51:47], i_beat[43:42],
                      i_beat[7:4], i_bar_hit_n};

endmodule

// File: rtl/pcie_rx_engine.sv
// PCIe TRN receive engine: turns single-DW MemWr32 TLPs into write strobes
// and MemRd32 TLPs into read requests; everything else is dropped and
// counted. Define PCIE_RX_MEM64_EN to also accept MemRd64/MemWr64.
//
// Handshakes: a TRN beat transfers on a cycle with trn_rsrc_rdy_n=0 and
// trn_rdst_rdy_n=0; a read request transfers on a cycle with req_valid=1
// and req_ready=1, and req_* stay stable while req_valid=1 waits on req_ready.
module pcie_rx_engine
  import pcie_tlp_pkg::*;
#(
  parameter int BAR_SEL = 0
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  output logic        trn_rdst_rdy_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [15:0] req_rid,
  output logic [7:0]  req_tag,
  output logic [2:0]  req_tc,
  output logic [1:0]  req_attr,
  output logic [3:0]  req_be,
  output logic [7:0]  drop_cnt,
  output logic [2:0]  o_dbg_state
);

  logic [2:0]  r_state, w_nxt;
  logic        r_rdst_rdy_n;
  logic        r_is_wr, r_is_64, r_ep;
  logic [2:0]  r_tc;
  logic [1:0]  r_attr;
  logic [15:0] r_rid;
  logic [7:0]  r_tag;
  logic [3:0]  r_be;
  logic        r_wr_en, r_req_valid;
  logic [31:0] r_wr_addr, r_wr_data, r_req_addr;
  logic [3:0]  r_wr_be;
  logic [7:0]  r_drop_cnt;
  logic        w_acc, w_hdr_ok, w_is_wr, w_is_64, w_ep;
  logic [2:0]  w_tc;
  logic [1:0]  w_attr;
  logic [15:0] w_rid;
  logic [7:0]  w_tag;
  logic [3:0]  w_be;
  logic [1:0]  w_drop_inc;
  logic        w_hdr_cap, w_wr_go, w_rd_go;
  logic [31:0] w_beat1_addr, w_addr_al, w_wr_addr, w_wr_dw;
  logic [8:0]  w_drop_sum;
  logic        w_unused;
`ifdef PCIE_RX_MEM64_EN
  logic [31:0] r_addr;
  logic        w_addr_cap;
`endif

  pcie_tlp_hdr_dec #(.BAR_SEL(BAR_SEL)) u_hdr_dec (
    .i_beat(trn_rd), .i_bar_hit_n(trn_rbar_hit_n), .o_ok(w_hdr_ok),
    .o_is_wr(w_is_wr), .o_is_64(w_is_64), .o_ep(w_ep), .o_tc(w_tc),
    .o_attr(w_attr), .o_rid(w_rid), .o_tag(w_tag), .o_be(w_be)
  );

  assign w_acc = ~trn_rsrc_rdy_n & ~r_rdst_rdy_n;

`ifdef PCIE_RX_MEM64_EN
  // 4DW headers carry the low address in DW3; upper address bits are ignored
  assign w_beat1_addr = r_is_64 ? trn_rd[31:0] : trn_rd[63:32];
  assign w_wr_addr    = (r_state == ST_DATA) ? r_addr : w_addr_al;
  assign w_wr_dw      = (r_state == ST_DATA) ? trn_rd[63:32] : trn_rd[31:0];
`else
  assign w_beat1_addr = trn_rd[63:32];
  assign w_wr_addr    = w_addr_al;
  assign w_wr_dw      = trn_rd[31:0];
`endif
  assign w_addr_al = {w_beat1_addr[31:2], 2'b00};

  // Next-state decode plus the per-cycle commit/drop decisions
  always_comb begin
    w_nxt      = r_state;
    w_drop_inc = 2'd0;
    w_hdr_cap  = 1'b0;
    w_wr_go    = 1'b0;
    w_rd_go    = 1'b0;
`ifdef PCIE_RX_MEM64_EN
    w_addr_cap = 1'b0;
`endif
    if (r_state == ST_RD_HOLD) begin
      if (req_ready) w_nxt = ST_IDLE;
    end else if (w_acc && !trn_rsof_n) begin
      // SOF anywhere restarts decoding; an interrupted TLP counts as a drop
      if (r_state != ST_IDLE) w_drop_inc = 2'd1;
      w_hdr_cap = 1'b1;
      if (!trn_reof_n) begin
        w_drop_inc = w_drop_inc + 2'd1;
        w_nxt      = ST_IDLE;
      end else if (w_hdr_ok) begin
        w_nxt = ST_HDR;
      end else begin
        w_nxt = ST_DISCARD;
      end
    end else if (w_acc && !trn_reof_n) begin
      case (r_state)
        ST_HDR: begin
          if (r_is_wr && r_is_64) begin
            w_drop_inc = 2'd1;
            w_nxt      = ST_IDLE;
          end else if (r_is_wr) begin
            if (r_ep) w_drop_inc = 2'd1;
            else      w_wr_go    = 1'b1;
            w_nxt = ST_IDLE;
          end else begin
            w_rd_go = 1'b1;
            w_nxt   = ST_RD_HOLD;
          end
        end
        ST_DISCARD: begin
          w_drop_inc = 2'd1;
          w_nxt      = ST_IDLE;
        end
`ifdef PCIE_RX_MEM64_EN
        ST_DATA: begin
          if (r_ep) w_drop_inc = 2'd1;
          else      w_wr_go    = 1'b1;
          w_nxt = ST_IDLE;
        end
`endif
        default: ;
      endcase
    end else if (w_acc) begin
      case (r_state)
`ifdef PCIE_RX_MEM64_EN
        ST_HDR: begin
          if (r_is_wr && r_is_64) begin
            w_addr_cap = 1'b1;
            w_nxt      = ST_DATA;
          end else begin
            w_nxt = ST_DISCARD;
          end
        end
        ST_DATA: w_nxt = ST_DISCARD;
`else
        ST_HDR: w_nxt = ST_DISCARD;
`endif
        default: ;
      endcase
    end
  end

  // State register; the sink stalls only while a read request is pending
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_state      <= ST_IDLE;
      r_rdst_rdy_n <= 1'b1;
    end else begin
      r_state      <= w_nxt;
      r_rdst_rdy_n <= (w_nxt == ST_RD_HOLD);
    end
  end

  // Capture beat-0 header fields (and the 4DW low address) for later beats
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_is_wr <= 1'b0; r_is_64 <= 1'b0; r_ep <= 1'b0; r_tc <= 3'd0;
      r_attr  <= 2'd0; r_rid <= 16'd0; r_tag <= 8'd0; r_be <= 4'd0;
`ifdef PCIE_RX_MEM64_EN
      r_addr  <= 32'd0;
`endif
    end else begin
      if (w_hdr_cap) begin
        r_is_wr <= w_is_wr; r_is_64 <= w_is_64; r_ep <= w_ep; r_tc <= w_tc;
        r_attr  <= w_attr;  r_rid <= w_rid; r_tag <= w_tag; r_be <= w_be;
      end
`ifdef PCIE_RX_MEM64_EN
      if (w_addr_cap) r_addr <= w_addr_al;
`endif
    end
  end

  // Write port: one-cycle strobe, address/data held until the next write
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_wr_en <= 1'b0; r_wr_addr <= 32'd0; r_wr_data <= 32'd0; r_wr_be <= 4'd0;
    end else begin
      r_wr_en <= w_wr_go;
      if (w_wr_go) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= bswap32(w_wr_dw);
        r_wr_be   <= r_be;
      end
    end
  end

  // Read request: raised after the address beat, dropped after handshake
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_req_valid <= 1'b0; r_req_addr <= 32'd0;
      req_rid <= 16'd0; req_tag <= 8'd0; req_tc <= 3'd0; req_attr <= 2'd0; req_be <= 4'd0;
    end else if (w_rd_go) begin
      r_req_valid <= 1'b1; r_req_addr <= w_addr_al;
      req_rid <= r_rid; req_tag <= r_tag; req_tc <= r_tc; req_attr <= r_attr; req_be <= r_be;
    end else if (r_req_valid && req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

  // Saturating count of discarded TLPs
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) r_drop_cnt <= 8'd0;
    else              r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  assign trn_rdst_rdy_n = r_rdst_rdy_n;
  assign wr_en          = r_wr_en;
  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign wr_be          = r_wr_be;
  assign req_valid      = r_req_valid;
  assign req_addr       = r_req_addr;
  assign drop_cnt       = r_drop_cnt;
  assign o_dbg_state    = r_state;

  // Remainder flags are redundant for the single-DW TLPs handled here
  assign w_unused = ^{trn_rrem_n, w_beat1_addr[1:0]};

endmodule

// File: tb/tb_pcie_rx_engine.sv
// Directed + randomized bench for pcie_rx_engine with a write scoreboard.
module tb_pcie_rx_engine;

  logic        trn_clk = 1'b0;
  logic        trn_reset_n = 1'b0;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = 8'h0F;
  logic        trn_rsof_n = 1'b1;
  logic        trn_reof_n = 1'b1;
  logic        trn_rsrc_rdy_n = 1'b1;
  logic        trn_rdst_rdy_n;
  logic [6:0]  trn_rbar_hit_n = 7'h7F;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic [15:0] req_rid;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [3:0]  req_be;
  logic [7:0]  drop_cnt;
  logic [2:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int bw;
  logic [67:0] exp_q[$];      // expected writes {addr, data, be}
  logic [64:0] exp_rd_q[$];   // expected requests {addr, rid, tag, tc, attr, be}
  logic [67:0] mon_got, mon_exp;

  localparam logic [6:0] BAR0 = 7'b1111110;
  localparam logic [6:0] BAR1 = 7'b1111101;

  pcie_rx_engine #(.BAR_SEL(0)) dut (
    .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_rd(trn_rd),
    .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
    .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rid(req_rid), .req_tag(req_tag), .req_tc(req_tc),
    .req_attr(req_attr), .req_be(req_be), .drop_cnt(drop_cnt), .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  always #5 trn_clk = ~trn_clk;

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Write monitor: every wr_en cycle must match the head of the scoreboard
  always @(negedge trn_clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      mon_got = {wr_addr, wr_data, wr_be};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got %h expected no write", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL wr_data: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [1:0] fmt, input logic [4:0] typ,
      input logic [9:0] len, input logic ep, input logic [2:0] tc, input logic [1:0] attr,
      input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] be);
    logic [63:0] d;
    d = '0;
    d[62:61] = fmt; d[60:56] = typ; d[54:52] = tc; d[46] = ep; d[45:44] = attr;
    d[41:32] = len; d[31:16] = rid; d[15:8] = tag; d[3:0] = be;
    return d;
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Driver: present a beat and hold it until the engine accepts it
  task automatic send_beat(input logic [63:0] d, input logic sof_n, input logic eof_n,
                           input logic [6:0] bar_n, output int waited);
    @(negedge trn_clk);
    trn_rd = d; trn_rsof_n = sof_n; trn_reof_n = eof_n;
    trn_rbar_hit_n = bar_n; trn_rsrc_rdy_n = 1'b0;
    waited = 0;
    while (trn_rdst_rdy_n !== 1'b0 && waited < 50) begin
      @(negedge trn_clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++; errors++;
      $display("FAIL beat_timeout: rdst_rdy_n=%b expected 0 within 50 cycles", trn_rdst_rdy_n);
    end
    @(posedge trn_clk);
  endtask

  task automatic idle();
    @(negedge trn_clk);
    trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      input logic [6:0] bar_n, input logic ep, input logic [9:0] len);
    send_beat(mk_hdr(2'b10, 5'd0, len, ep, 3'd0, 2'd0, 16'h0001, 8'h00, be), 1'b0, 1'b1, bar_n, bw);
    send_beat({addr, data}, 1'b1, 1'b0, bar_n, bw);
  endtask

  task automatic check_drop(input string name);
    checks++;
    if (drop_cnt !== exp_drop[7:0]) begin
      errors++;
      $display("FAIL %s: drop_cnt=%0d expected %0d", name, drop_cnt, exp_drop);
    end
  endtask

  task automatic check_wr_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes never seen", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    repeat (3) @(negedge trn_clk);
    checks++;
    if (o_dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state); end
    checks++;
    if (trn_rdst_rdy_n !== 1'b1) begin errors++; $display("FAIL reset_rdst: got %b expected 1", trn_rdst_rdy_n); end
    checks++;
    if ({wr_en, req_valid, drop_cnt} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl: wr_en=%b req_valid=%b drop_cnt=%0d expected 0", wr_en, req_valid, drop_cnt);
    end
    checks++;
    if ({wr_addr, wr_data, wr_be, req_addr, req_rid, req_tag, req_tc, req_attr, req_be} !== '0) begin
      errors++; $display("FAIL reset_data: wr_addr=%h wr_data=%h req_addr=%h expected 0", wr_addr, wr_data, req_addr);
    end
    trn_reset_n = 1'b1;
    exp_drop = 0;
    @(negedge trn_clk);
    checks++;
    if (trn_rdst_rdy_n !== 1'b0) begin errors++; $display("FAIL reset_release: rdst_rdy_n=%b expected 0", trn_rdst_rdy_n); end
  endtask

  task automatic test_mem_wr32();
    logic [31:0] a, d;
    logic [3:0]  be;
    exp_q.push_back({32'h0000_0010, 32'h4433_2211, 4'hF});
    wr32(32'h0000_0010, 32'h1122_3344, 4'hF, BAR0, 1'b0, 10'd1);
    idle();
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL wr_latency: wr_en=%b expected 1", wr_en); end
    @(negedge trn_clk);
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: wr_en=%b expected 0", wr_en); end
    check_wr_drained("wr32_seen");
    check_drop("wr32_drop");
    for (int i = 0; i < 5; i++) begin
      a  = $urandom;
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      exp_q.push_back({a[31:2], 2'b00, swap(d), be});
      wr32(a, d, be, BAR0, 1'b0, 10'd1);
    end
    idle();
    @(negedge trn_clk);
    check_wr_drained("wr32_random");
    check_drop("wr32_random_drop");
  endtask

  task automatic test_mem_rd32();
    logic [64:0] exp;
    exp_rd_q.push_back({32'h0000_0020, 16'h0100, 8'h05, 3'd2, 2'd1, 4'hF});
    req_ready = 1'b0;
    send_beat(mk_hdr(2'b00, 5'd0, 10'd1, 1'b0, 3'd2, 2'd1, 16'h0100, 8'h05, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat({32'h0000_0023, 32'h0}, 1'b1, 1'b0, BAR0, bw);
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge trn_clk);
      checks++;
      if (req_valid !== 1'b1 || trn_rdst_rdy_n !== 1'b1 || o_dbg_state !== 3'd2) begin
        errors++;
        $display("FAIL rd_hold%0d: req_valid=%b rdst_rdy_n=%b state=%0d expected 1 1 2",
                 i, req_valid, trn_rdst_rdy_n, o_dbg_state);
      end
      checks++;
      if ({req_addr, req_rid, req_tag, req_tc, req_attr, req_be} !== exp_rd_q[0]) begin
        errors++;
        $display("FAIL rd_fields%0d: got %h expected %h", i,
                 {req_addr, req_rid, req_tag, req_tc, req_attr, req_be}, exp_rd_q[0]);
      end
    end
    @(negedge trn_clk);
    req_ready = 1'b1;
    exp = exp_rd_q.pop_front();
    checks++;
    if ({req_valid, req_addr, req_rid, req_tag, req_tc, req_attr, req_be} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL rd_handshake: got %b/%h expected 1/%h", req_valid,
               {req_addr, req_rid, req_tag, req_tc, req_attr, req_be}, exp);
    end
    @(posedge trn_clk);
    @(negedge trn_clk);
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || trn_rdst_rdy_n !== 1'b0 || o_dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL rd_release: req_valid=%b rdst_rdy_n=%b state=%0d expected 0 0 0",
               req_valid, trn_rdst_rdy_n, o_dbg_state);
    end
    // back-to-back: a write starts on the very cycle after the handshake
    exp_q.push_back({32'h0000_0100, 32'hEFBE_ADDE, 4'h3});
    trn_rd = mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h0002, 8'h01, 4'h3);
    trn_rsof_n = 1'b0; trn_reof_n = 1'b1; trn_rbar_hit_n = BAR0; trn_rsrc_rdy_n = 1'b0;
    @(posedge trn_clk);
    send_beat({32'h0000_0100, 32'hDEAD_BEEF}, 1'b1, 1'b0, BAR0, bw);
    idle();
    @(negedge trn_clk);
    check_wr_drained("back_to_back");
    check_drop("rd_drop");
  endtask

  task automatic test_drops();
    send_beat(mk_hdr(2'b10, 5'd0, 10'd2, 1'b0, 3'd0, 2'd0, 16'h3, 8'h0, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat({32'h0000_0030, 32'h0102_0304}, 1'b1, 1'b1, BAR0, bw);
    send_beat({32'h0506_0708, 32'h0}, 1'b1, 1'b0, BAR0, bw);
    exp_drop = sat_inc(exp_drop);
    send_beat(mk_hdr(2'b10, 5'b00100, 10'd1, 1'b0, 3'd0, 2'd0, 16'h3, 8'h0, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat({32'h0000_0040, 32'hAAAA_5555}, 1'b1, 1'b0, BAR0, bw);
    exp_drop = sat_inc(exp_drop);
    wr32(32'h0000_0050, 32'h1234_5678, 4'hF, BAR1, 1'b0, 10'd1);
    exp_drop = sat_inc(exp_drop);
    wr32(32'h0000_0060, 32'h8765_4321, 4'hF, BAR0, 1'b1, 10'd1);
    exp_drop = sat_inc(exp_drop);
    idle();
    @(negedge trn_clk);
    check_drop("drop_four");
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL drop_req: req_valid=%b expected 0", req_valid); end
    // single-beat TLP is counted; stray non-SOF beats in IDLE are not
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h3, 8'h0, 4'hF), 1'b0, 1'b0, BAR0, bw);
    exp_drop = sat_inc(exp_drop);
    send_beat({32'h0000_0070, 32'h1}, 1'b1, 1'b0, BAR0, bw);
    send_beat({32'h0000_0074, 32'h2}, 1'b1, 1'b1, BAR0, bw);
    idle();
    @(negedge trn_clk);
    check_drop("single_and_stray");
    checks++;
    if (o_dbg_state !== 3'd0) begin errors++; $display("FAIL stray_state: got %0d expected 0", o_dbg_state); end
  endtask

  task automatic test_sof_abort();
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h4, 8'h1, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h4, 8'h2, 4'hC), 1'b0, 1'b1, BAR0, bw);
    exp_drop = sat_inc(exp_drop);
    exp_q.push_back({32'h0000_0080, 32'hDDCC_BBAA, 4'hC});
    send_beat({32'h0000_0080, 32'hAABB_CCDD}, 1'b1, 1'b0, BAR0, bw);
    // abort out of DISCARD as well
    send_beat(mk_hdr(2'b10, 5'd0, 10'd3, 1'b0, 3'd0, 2'd0, 16'h4, 8'h3, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h4, 8'h4, 4'h1), 1'b0, 1'b1, BAR0, bw);
    exp_drop = sat_inc(exp_drop);
    exp_q.push_back({32'h0000_0090, 32'h0403_0201, 4'h1});
    send_beat({32'h0000_0091, 32'h0102_0304}, 1'b1, 1'b0, BAR0, bw);
    idle();
    @(negedge trn_clk);
    check_wr_drained("sof_abort_wr");
    check_drop("sof_abort_drop");
  endtask

  task automatic test_reset_mid();
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h5, 8'h0, 4'hF), 1'b0, 1'b1, BAR0, bw);
    @(negedge trn_clk);
    trn_rsrc_rdy_n = 1'b1;
    trn_reset_n = 1'b0;
    repeat (2) @(negedge trn_clk);
    trn_reset_n = 1'b1;
    exp_drop = 0;
    send_beat({32'h0000_00A0, 32'hCAFE_F00D}, 1'b1, 1'b0, BAR0, bw);
    idle();
    @(negedge trn_clk);
    checks++;
    if (o_dbg_state !== 3'd0) begin errors++; $display("FAIL reset_mid_state: got %0d expected 0", o_dbg_state); end
    check_drop("reset_mid_drop");
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_mid_wr: wr_en=%b expected 0", wr_en); end
  endtask

  task automatic test_mem64();
    send_beat(mk_hdr(2'b11, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h6, 8'h0, 4'hF), 1'b0, 1'b1, BAR0, bw);
    send_beat({32'h0000_0000, 32'h0000_0040}, 1'b1, 1'b1, BAR0, bw);
`ifdef PCIE_RX_MEM64_EN
    exp_q.push_back({32'h0000_0040, 32'h8877_6655, 4'hF});
`else
    exp_drop = sat_inc(exp_drop);
`endif
    send_beat({32'h5566_7788, 32'h0}, 1'b1, 1'b0, BAR0, bw);
    idle();
    @(negedge trn_clk);
    check_wr_drained("mem64_wr");
    check_drop("mem64_drop");
  endtask

  task automatic test_saturate();
    int mode;
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h7, 8'h0, 4'hF), 1'b0, 1'b0, BAR0, bw);
      end else if (mode == 1) begin
        wr32($urandom, $urandom, 4'hF, BAR1, 1'b0, 10'd1);
      end else begin
        wr32($urandom, $urandom, 4'hF, BAR0, 1'b0, 10'($urandom_range(2, 8)));
      end
      exp_drop = sat_inc(exp_drop);
    end
    idle();
    @(negedge trn_clk);
    checks++;
    if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL saturate: drop_cnt=%h expected ff", drop_cnt); end
    send_beat(mk_hdr(2'b10, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h7, 8'h0, 4'hF), 1'b0, 1'b0, BAR0, bw);
    idle();
    @(negedge trn_clk);
    check_drop("saturate_hold");
  endtask

  initial begin
    test_reset();
    test_mem_wr32();
    test_mem_rd32();
    test_drops();
    test_sof_abort();
    test_reset_mid();
    test_mem64();
    test_saturate();
    repeat (2) @(negedge trn_clk);
    check_wr_drained("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_rx_engine.md
PCIE_RX_ENGINE -- requirements
Module: pcie_rx_engine

Interface
REQ-001 SHALL have parameter BAR_SEL, default 0, meaning the index of trn_rbar_hit_n whose assertion qualifies a TLP.
REQ-002 SHALL have ports trn_clk in 1 (sole clock), trn_reset_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL have TRN RX ports:
  - trn_rd in 64
  - trn_rrem_n in 8
  - trn_rsof_n in 1
  - trn_reof_n in 1
  - trn_rsrc_rdy_n in 1
  - trn_rdst_rdy_n out 1
  - trn_rbar_hit_n in 7
REQ-004 SHALL have write ports:
  - wr_en out 1 (single-cycle strobe)
  - wr_addr out 32 (byte address, bits [1:0]=0)
  - wr_data out 32
  - wr_be out 4
REQ-005 SHALL have read-request ports:
  - req_valid out 1
  - req_ready in 1
  - req_addr out 32
  - req_rid out 16
  - req_tag out 8
  - req_tc out 3
  - req_attr out 2
  - req_be out 4
REQ-006 SHALL have drop_cnt out 8 (saturating count of discarded TLPs).

Function
REQ-007 SHALL treat a beat as accepted when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0.
REQ-008 SHALL decode beat 0 as {DW0,DW1} with DW0 in [63:32]:
  - fmt=[62:61], type=[60:56], TC=[54:52], EP=[46], attr=[45:44], length=[41:32]
  - requester ID=[31:16], tag=[15:8], first BE=[3:0]
REQ-009 SHALL decode beat 1 of a 3DW header as DW2 in [63:32] (address, with address[1:0] forced to 0) and DW3 in [31:0] (write data).
REQ-010 SHALL byte-swap write data: wr_data = {DW3[7:0],DW3[15:8],DW3[23:16],DW3[31:24]}.
REQ-011 SHALL use states IDLE, HDR, RD_HOLD and DISCARD.
REQ-012 IDLE SHALL act only on an accepted beat with trn_rsof_n=0:
  - go to HDR for MemRd32 (fmt=00, type=00000) or MemWr32 (fmt=10, type=00000) with length=1 and bar hit BAR_SEL asserted;
  - otherwise go to DISCARD.
REQ-013 HDR, on an accepted beat with trn_reof_n=0:
  - for a write with EP=0, pulse wr_en for exactly one cycle, in the cycle after acceptance, then go to IDLE;
  - for a write with EP=1, go to IDLE, drop the write and increment drop_cnt;
  - for a read, assert req_valid in the cycle after acceptance and go to RD_HOLD.
REQ-014 RD_HOLD:
  - SHALL hold req_* stable and trn_rdst_rdy_n=1;
  - on req_valid=1 and req_ready=1, SHALL clear req_valid in the next cycle and go to IDLE.
REQ-015 DISCARD SHALL consume beats until one is accepted with trn_reof_n=0, then go to IDLE and increment drop_cnt once.
REQ-016 trn_rdst_rdy_n SHALL be 0 in every state except RD_HOLD.
REQ-017 An accepted beat with trn_rsof_n=0 outside IDLE SHALL count the aborted TLP in drop_cnt and restart decoding from that beat as in IDLE.
REQ-018 A single-beat TLP (rsof and reof both asserted on beat 0) SHALL be discarded and counted.
REQ-019 drop_cnt SHALL saturate at 8'hFF.
REQ-020 Beats accepted in IDLE without trn_rsof_n=0 SHALL be ignored and not counted.
REQ-021 Read-to-req_valid latency SHALL be 1 cycle, and a back-to-back TLP SHALL be accepted in the cycle after req_ready handshakes.

Reset
REQ-022 While trn_reset_n=0:
  - state=IDLE
  - trn_rdst_rdy_n=1
  - wr_en=0, req_valid=0, drop_cnt=0
  - all data/address outputs 0
REQ-023 Reset asserted mid-TLP SHALL abandon the TLP without counting it, and any following non-SOF beats SHALL be ignored per REQ-020.

Configuration
REQ-024 With macro PCIE_RX_MEM64_EN defined, the block SHALL also accept MemRd64 (fmt=01) and MemWr64 (fmt=11):
  - beat 1 = {DW2 upper address, DW3 lower address};
  - the write data DW is in [63:32] of beat 2;
  - upper address bits are ignored;
  - this adds a DATA state between HDR and IDLE.
REQ-025 Without PCIE_RX_MEM64_EN, 4DW TLPs SHALL be discarded and counted per REQ-015.

Structure
REQ-026 A shared package pcie_tlp_pkg SHALL hold:
  - fmt/type constants (MRD32, MWR32, MRD64, MWR64);
  - the header field bit positions;
  - the state enumeration.
REQ-027 The block SHALL be monolithic, except for an optional sub-module pcie_tlp_hdr_dec (combinational beat-0 field extraction and classification).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - MemWr32: addr 0x0000_0010, data DW 0x11223344, BE 0xF, bar0 hit -> one wr_en pulse with wr_addr=0x10, wr_data=0x44332211, wr_be=0xF; drop_cnt=0.
  - MemRd32: addr 0x20, tag 0x05, RID 0x0100, req_ready held 0 for 5 cycles -> req_valid stays high with stable fields; trn_rdst_rdy_n=1 for those 5 cycles; released 1 cycle after the handshake.
  - Write with length=2, a Cfg TLP, a bar1-only hit and an EP=1 write -> no wr_en or req_valid; drop_cnt=4.
  - New SOF arrives in HDR before EOF -> drop_cnt+1 and the new TLP is processed normally.
  - trn_reset_n pulsed low mid-write, then a non-SOF beat -> no wr_en, state IDLE, drop_cnt=0.
  - 300 discarded TLPs -> drop_cnt=0xFF; with PCIE_RX_MEM64_EN, MemWr64 to 0x0000_0000_0000_0040 -> wr_addr=0x40.
